ccff_chain_loader: RTL and testbench

//  Configuration-chain controller for a connection-block tile. Accepts bitstream words over a

---
 rtl/ccff_chain_loader.sv | 135 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts bitstream words over valid/ready, shifts them MSB-first onto a
// tile configuration chain, and can rotate the chain once through ccff_tail to compare it
// against a shadow copy of what was loaded.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8
) (
    input  logic                         prog_clk,
    input  logic                         pReset,
    input  logic                         start,
    input  logic                         verify_en,
    input  logic [WORD_W-1:0]            word_in,
    input  logic                         word_valid,
    output logic                         word_ready,
    output logic                         config_enable,
    output logic                         ccff_head,
    input  logic                         ccff_tail_in,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(CHAIN_LEN)-1:0] err_idx
);
    localparam int IW  = $clog2(CHAIN_LEN);
    localparam int WCW = $clog2(WORD_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHAIN_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state;
    logic                 verify_q;
    logic [IW-1:0]        bitcnt;
    logic [IW-1:0]        vcnt;
    logic [WCW-1:0]       wbits;
    logic [WORD_W-1:0]    shreg;
    logic [CHAIN_LEN-1:0] shadow;

    // Number of bits of the next word that still fit in the chain: a full word, or the
    // remainder when the chain end falls inside the word (its low bits are then dropped).
    function automatic logic [WCW-1:0] word_bits(input logic [IW-1:0] pos);
        int rem;
        rem = CHAIN_LEN - int'(pos);
        if (rem >= WORD_W) return WCW'(WORD_W);
        return WCW'(rem);
    endfunction

    // Handshake, chain enable and serial data decoded from the state register; the chain
    // only moves while config_enable is high, so stalls in LOAD leave it untouched.
    always_comb begin
        word_ready    = (state == S_LOAD);
        config_enable = (state == S_SHIFT) || (state == S_VERIFY);
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        ccff_head     = 1'b0;
        if (state == S_SHIFT) begin
            ccff_head = shreg[WORD_W-1];
        end else if (state == S_VERIFY) begin
            // Loopback so that one full rotation restores the chain contents.
            ccff_head = ccff_tail_in;
        end
    end

    // Load/shift/verify sequencer with bit counters, shadow copy and sticky mismatch flag.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state    <= S_IDLE;
            verify_q <= 1'b0;
            bitcnt   <= '0;
            vcnt     <= '0;
            wbits    <= '0;
            shreg    <= '0;
            shadow   <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        verify_q <= verify_en;
                        err      <= 1'b0;
                        err_idx  <= '0;
                        bitcnt   <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        shreg <= word_in;
                        wbits <= word_bits(bitcnt);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shadow[bitcnt] <= shreg[WORD_W-1];
                    shreg          <= shreg << 1;
                    bitcnt         <= bitcnt + IW'(1);
                    wbits          <= wbits - WCW'(1);
                    if (wbits == WCW'(1)) begin
                        if (bitcnt == LAST_IDX) begin
                            if (verify_q) begin
                                vcnt  <= '0;
                                state <= S_VERIFY;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_VERIFY: begin
                    // Readback cycle k presents bit k; only the first mismatch is recorded.
                    if ((ccff_tail_in != shadow[vcnt]) && !err) begin
                        err     <= 1'b1;
                        err_idx <= vcnt;
                    end
                    vcnt <= vcnt + IW'(1);
                    if (vcnt == LAST_IDX) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a table of directed operations, hand-written sequences for
// mid-operation reset and a short chain with a partial final word, then randomized operations
// against a bitstream/chain model.
module tb_ccff_chain_loader;
    localparam int CL  = 48;
    localparam int WW  = 8;
    localparam int CL2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, ven, wvalid, wready, cen, head, tail, busy, done, err;
    logic [WW-1:0] word;
    logic [5:0]    eidx;

    logic          b_start, b_ven, b_wvalid, b_wready, b_cen, b_head, b_tail, b_busy, b_done, b_err;
    logic [WW-1:0] b_word;
    logic [3:0]    b_eidx;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
        .prog_clk(clk), .pReset(rst), .start(start), .verify_en(ven),
        .word_in(word), .word_valid(wvalid), .word_ready(wready),
        .config_enable(cen), .ccff_head(head), .ccff_tail_in(tail),
        .busy(busy), .done(done), .err(err), .err_idx(eidx)
    );

    ccff_chain_loader #(.CHAIN_LEN(CL2), .WORD_W(WW)) u_dut12 (
        .prog_clk(clk), .pReset(rst), .start(b_start), .verify_en(b_ven),
        .word_in(b_word), .word_valid(b_wvalid), .word_ready(b_wready),
        .config_enable(b_cen), .ccff_head(b_head), .ccff_tail_in(b_tail),
        .busy(b_busy), .done(b_done), .err(b_err), .err_idx(b_eidx)
    );

    // Tile chain model: a plain shift register moving on config_enable; inj_mask is ORed
    // in right after the enable numbered inj_at to emulate corrupted SRAM bits.
    logic [CL-1:0] chain, chain_nxt, inj_mask;
    int            en_cnt;
    int            inj_at;
    assign tail = chain[CL-1];

    always_comb begin
        chain_nxt = chain;
        if (cen) begin
            chain_nxt = {chain[CL-2:0], head};
            if (en_cnt == inj_at) chain_nxt = chain_nxt | inj_mask;
        end
    end

    always_ff @(posedge clk) begin
        chain <= chain_nxt;
        if (rst) en_cnt <= 0;
        else if (cen) en_cnt <= en_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Operation stimulus and observations
    logic [WW-1:0] op_words [8];
    int            op_gaps  [8];
    int            op_nw;
    logic [127:0]  got_v;
    int            n_en, done_c, n_done, bad_head;
    logic          busy0, err0, busy_end, err_end, op_fin;
    logic [5:0]    eidx0, eidx_end;

    // Model results
    logic [127:0]  exp_stream;
    logic [CL-1:0] exp_chain;
    int            exp_en_m, exp_lat_m, exp_idx_m;
    logic          exp_err_m;

    // Expected serial stream, final chain, latency and readback result from the word list.
    task automatic build_model(input bit ver, input logic [CL-1:0] frc);
        logic [CL-1:0] bits;
        int pos;
        bits = '0; exp_stream = '0; pos = 0;
        exp_lat_m = ver ? CL : 0;
        for (int i = 0; i < op_nw; i++) begin
            int take;
            take = (CL - pos < WW) ? CL - pos : WW;
            exp_lat_m += op_gaps[i] + 1 + take;
            for (int b = 0; b < take; b++) begin
                bits[6'(pos)] = op_words[i][3'(WW - 1 - b)];
                exp_stream[7'(pos)] = bits[6'(pos)];
                pos++;
            end
        end
        exp_err_m = 1'b0; exp_idx_m = 0;
        exp_en_m = ver ? 2 * CL : CL;
        for (int k = 0; k < CL; k++) begin
            logic rb;
            rb = bits[6'(k)] | frc[6'(k)];
            exp_chain[6'(CL - 1 - k)] = rb;
            if (ver) begin
                exp_stream[7'(CL + k)] = rb;
                if (!exp_err_m && rb != bits[6'(k)]) begin
                    exp_err_m = 1'b1;
                    exp_idx_m = k;
                end
            end
        end
    endtask

    // Issue start, feed words (op_gaps[i] idle LOAD cycles before word i), pulse a stray
    // start at cycle 'poke', and record everything until three cycles after done.
    task automatic run_op(input bit ver, input int poke);
        int wi, gap;
        bit pend;
        got_v = '0; n_en = 0; done_c = -1; n_done = 0; bad_head = 0; op_fin = 1'b0;
        wi = 0; gap = op_gaps[0]; pend = 1'b0;
        inj_at = en_cnt + CL - 1;
        start = 1'b1; ven = ver; wvalid = 1'b0;
        for (int c = 0; c < 800 && !op_fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            ven = ~ver;
            if (c == 0) begin busy0 = busy; err0 = err; eidx0 = eidx; end
            if (pend) begin
                wi++; wvalid = 1'b0; pend = 1'b0;
                if (wi < op_nw) gap = op_gaps[wi];
            end
            if (cen) begin
                if (n_en < 128) got_v[7'(n_en)] = head;
                n_en++;
            end else if (head !== 1'b0) begin
                bad_head++;
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 3) begin
                op_fin = 1'b1; busy_end = busy; err_end = err; eidx_end = eidx;
            end
            if (c == poke) start = 1'b1;
            if (!wvalid && wi < op_nw) begin
                if (gap == 0) begin
                    wvalid = 1'b1;
                    word = op_words[wi];
                end else if (wready) begin
                    gap--;
                end
            end
            if (wvalid && wready) pend = 1'b1;
        end
        wvalid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_checked(input string tag, input bit ver, input logic [CL-1:0] frc,
                               input int poke, input int x_en, input int x_lat,
                               input bit x_err, input int x_idx);
        build_model(ver, frc);
        if (x_en < 0) begin
            x_en = exp_en_m; x_lat = exp_lat_m; x_err = exp_err_m; x_idx = exp_idx_m;
        end
        inj_mask = '0;
        for (int k = 0; k < CL; k++) inj_mask[6'(CL - 1 - k)] = frc[6'(k)];
        run_op(ver, poke);
        chk({tag, "_finished"}, 128'(op_fin), 128'(1));
        if (!op_fin) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        chk({tag, "_start_state"}, 128'({busy0, err0, eidx0}), 128'({1'b1, 1'b0, 6'd0}));
        chk({tag, "_enables"}, 128'(n_en), 128'(x_en));
        chk({tag, "_done_latency"}, 128'(done_c), 128'(x_lat));
        chk({tag, "_done_pulses"}, 128'(n_done), 128'(1));
        chk({tag, "_head_idle_zero"}, 128'(bad_head), 128'(0));
        chk({tag, "_stream"}, got_v, exp_stream);
        chk({tag, "_chain"}, 128'(chain), 128'(exp_chain));
        chk({tag, "_end_state"}, 128'({busy_end, err_end, eidx_end}),
            128'({1'b0, x_err, 6'(x_idx)}));
    endtask

    typedef struct {
        logic [47:0]   words;
        bit            ver;
        int            gap;
        logic [CL-1:0] frc;
        int            poke;
        int            x_en;
        int            x_lat;
        bit            x_err;
        int            x_idx;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int wi, n, nbad, bdone_c, bn_en, bdn;
        bit pend, hit, bfin;
        logic [15:0] bbits;

        tbl[0] = '{48'hA53CFF00817E, 1'b0, 0, '0, -1, 48, 54, 1'b0, 0};
        tbl[1] = '{48'hA53CFF00817E, 1'b1, 0, '0, 30, 96, 102, 1'b0, 0};
        tbl[2] = '{48'hA53C00FF817E, 1'b1, 0, (48'd1 << 17) | (48'd1 << 40), 70, 96, 102, 1'b1, 17};
        tbl[3] = '{48'hA53CFF00817E, 1'b0, 5, '0, 10, 48, 84, 1'b0, 0};
        tbl[4] = '{48'hFF00FF00FF00, 1'b1, 0, 48'd1 << 47, -1, 96, 102, 1'b1, 47};

        inj_at = -1; inj_mask = '0;
        rst = 1'b1; start = 1'b0; ven = 1'b0; wvalid = 1'b1; word = 8'hFF;
        b_start = 1'b0; b_ven = 1'b0; b_wvalid = 1'b0; b_word = '0; b_tail = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({wready, cen, head, busy, done, err, eidx}), 128'(0));
        chk("reset_outputs12", 128'({b_wready, b_cen, b_head, b_busy, b_done, b_err, b_eidx}), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_valid_not_accepted", 128'({wready, busy, cen}), 128'(0));
        wvalid = 1'b0;

        for (int t = 0; t < 5; t++) begin
            op_nw = 6;
            for (int i = 0; i < 6; i++) begin
                op_words[i] = tbl[t].words[6'(47 - 8 * i) -: 8];
                op_gaps[i]  = tbl[t].gap;
            end
            run_checked($sformatf("tbl%0d", t), tbl[t].ver, tbl[t].frc, tbl[t].poke,
                        tbl[t].x_en, tbl[t].x_lat, tbl[t].x_err, tbl[t].x_idx);
        end

        // Reset on the 20th SHIFT cycle of a verify load
        op_words[0] = 8'hA5; op_words[1] = 8'h3C; op_words[2] = 8'hFF;
        op_words[3] = 8'h00; op_words[4] = 8'h81; op_words[5] = 8'h7E;
        start = 1'b1; ven = 1'b1; wvalid = 1'b0;
        n = 0; wi = 0; pend = 1'b0; hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pend) begin wi++; pend = 1'b0; end
            if (cen) n++;
            if (n == 20) begin
                rst = 1'b1; wvalid = 1'b0; hit = 1'b1;
            end else begin
                wvalid = (wi < 6);
                word = op_words[wi < 6 ? wi : 0];
                pend = wvalid && wready;
            end
        end
        chk("rst_reached_shift20", 128'(hit), 128'(1));
        @(negedge clk);
        chk("rst_mid_shift_outputs", 128'({busy, cen, done, wready, head}), 128'(0));
        rst = 1'b0;
        nbad = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy || cen) nbad++;
        end
        chk("rst_no_done_after", 128'(nbad), 128'(0));

        // Randomized operations
        for (int r = 0; r < 16; r++) begin
            bit ver;
            logic [CL-1:0] frc;
            int poke;
            op_nw = 6;
            for (int i = 0; i < 6; i++) begin
                op_words[i] = 8'($urandom);
                op_gaps[i]  = int'($urandom_range(0, 3));
            end
            ver = 1'($urandom_range(0, 1));
            frc = '0;
            if ($urandom_range(0, 1) == 1)
                frc = CL'({$urandom, $urandom}) & CL'({$urandom, $urandom}) & CL'({$urandom, $urandom});
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : -1;
            run_checked($sformatf("rnd%0d", r), ver, frc, poke, -1, 0, 1'b0, 0);
        end

        // 12-bit chain: second word only partly fits, its low nibble is dropped
        b_start = 1'b1;
        wi = 0; pend = 1'b0; bn_en = 0; bbits = '0; bdone_c = -1; bfin = 1'b0; bdn = 0;
        for (int c = 0; c < 100 && !bfin; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (pend) begin wi++; pend = 1'b0; end
            if (b_cen) begin
                if (bn_en < 16) bbits[4'(bn_en)] = b_head;
                bn_en++;
            end
            if (b_done) begin
                bdn++;
                if (bdone_c < 0) bdone_c = c;
            end
            if (bdone_c >= 0 && c == bdone_c + 3) bfin = 1'b1;
            b_wvalid = (wi < 2);
            b_word = (wi == 0) ? 8'hF0 : 8'hAB;
            pend = b_wvalid && b_wready;
        end
        b_wvalid = 1'b0;
        chk("c12_finished", 128'(bfin), 128'(1));
        chk("c12_enables", 128'(bn_en), 128'(12));
        chk("c12_stream", 128'(bbits), 128'(16'h050F));
        chk("c12_done_latency", 128'(bdone_c), 128'(14));
        chk("c12_done_pulses", 128'(bdn), 128'(1));
        chk("c12_end_state", 128'({b_busy, b_err, b_wready, wi}), 128'({1'b0, 1'b0, 1'b0, 32'd2}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
